// File: rtl/ifetch_icache_if.sv
// Fetch-unit bus: memory-controller fetch port plus the
// valid/ready instruction hand-off to the decoder.
interface ifetch_icache_if;
    logic        mem_if_enable;
    logic [31:0] mem_if_pc;
    logic        mem_if_done;
    logic [31:0] mem_if_result;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output mem_if_enable,
        output mem_if_pc,
        input  mem_if_done,
        input  mem_if_result,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  mem_if_enable,
        input  mem_if_pc,
        output mem_if_done,
        output mem_if_result,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/ifetch_icache.sv
// Instruction fetch front end with a direct-mapped, one-word-per-line
// instruction cache and a single-entry holding register to the decoder.
module ifetch_icache #(
    parameter int          INDEX_W  = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          clr,
    input  logic [31:0]   clr_pc,
    ifetch_icache_if.master bus
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W;

    typedef enum logic {LOOKUP, MISS_WAIT} state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic               mem_en_q, mem_en_d;
    logic [31:0]        mem_pc_q, mem_pc_d;
    logic               inst_valid_q, inst_valid_d;
    logic [31:0]        inst_q, inst_d;
    logic [31:0]        inst_pc_q, inst_pc_d;

    logic [TAG_W-1:0]   tag_ram  [LINES];
    logic [31:0]        data_ram [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               slot_free;
    logic               fill_we;

    assign idx       = pc_q[INDEX_W+1:2];
    assign tag       = pc_q[31:INDEX_W+2];
    assign hit       = valid_q[idx] && (tag_ram[idx] == tag);
    assign slot_free = !inst_valid_q || bus.inst_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        mem_en_d     = mem_en_q;
        mem_pc_d     = mem_pc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fill_we      = 1'b0;
        if (rdy) begin
            // A returning word is cached even when a flush drops it.
            if (state_q == MISS_WAIT && bus.mem_if_done) begin
                fill_we      = 1'b1;
                valid_d[idx] = 1'b1;
            end
            if (clr) begin
                pc_d         = clr_pc & ~32'h3;
                inst_valid_d = 1'b0;
                mem_en_d     = 1'b0;
                state_d      = LOOKUP;
            end else begin
                if (inst_valid_q && bus.inst_ready)
                    inst_valid_d = 1'b0;
                unique case (state_q)
                    LOOKUP: begin
                        if (slot_free) begin
                            if (hit) begin
                                inst_d       = data_ram[idx];
                                inst_pc_d    = pc_q;
                                inst_valid_d = 1'b1;
                                pc_d         = pc_q + 32'd4;
                            end else begin
                                mem_en_d = 1'b1;
                                mem_pc_d = pc_q;
                                state_d  = MISS_WAIT;
                            end
                        end
                    end
                    MISS_WAIT: begin
                        if (bus.mem_if_done) begin
                            inst_d       = bus.mem_if_result;
                            inst_pc_d    = pc_q;
                            inst_valid_d = 1'b1;
                            pc_d         = pc_q + 32'd4;
                            mem_en_d     = 1'b0;
                            state_d      = LOOKUP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= LOOKUP;
            pc_q         <= RESET_PC;
            valid_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_pc_q     <= 32'h0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            mem_en_q     <= mem_en_d;
            mem_pc_q     <= mem_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_ram[idx]  <= tag;
            data_ram[idx] <= bus.mem_if_result;
        end
    end

    assign bus.mem_if_enable = mem_en_q;
    assign bus.mem_if_pc     = mem_pc_q;
    assign bus.inst_valid    = inst_valid_q;
    assign bus.inst          = inst_q;
    assign bus.inst_pc       = inst_pc_q;
endmodule

// File: tb/tb_ifetch_icache.sv
// Bench for ifetch_icache: memory responder plus a reference model of
// the expected sequential fetch stream and of cache contents.
module tb_ifetch_icache;
    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        rdy    = 1'b0;
    logic        clr    = 1'b0;
    logic [31:0] clr_pc = 32'h0;

    ifetch_icache_if bus ();

    ifetch_icache #(.INDEX_W(8), .RESET_PC(32'h0)) dut (
        .clk    (clk),
        .rst    (rst),
        .rdy    (rdy),
        .clr    (clr),
        .clr_pc (clr_pc),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit          mv [256];
    logic [21:0] mt [256];
    logic [31:0] exp_pc    = 32'h0;
    bit          req_since = 1'b0;
    bit          busy      = 1'b0;
    int          cnt       = 0;
    int          lat       = 3;
    bit          rand_lat  = 1'b0;
    logic [31:0] raddr     = 32'h0;
    logic        p_en, p_v;
    logic [31:0] p_pc, p_inst, p_ipc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00000013;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000 ^ {a[9:2], 24'h0};
    endfunction

    function automatic bit mhit(input logic [31:0] a);
        return mv[a[9:2]] && (mt[a[9:2]] === a[31:10]);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        p_en  = bus.mem_if_enable;
        p_pc  = bus.mem_if_pc;
        p_v   = bus.inst_valid;
        p_inst = bus.inst;
        p_ipc = bus.inst_pc;
    endtask

    task automatic tick(input bit rd, input bit en_i, input bit cl,
                        input logic [31:0] cpc);
        bit dn;
        rdy            = en_i;
        clr            = cl;
        clr_pc         = cpc;
        bus.inst_ready = rd;
        dn = busy && en_i && (cnt == 0);
        bus.mem_if_done   = dn;
        bus.mem_if_result = dn ? mem_word(raddr) : $urandom;
        @(posedge clk);
        #1;
        if (en_i) begin
            if (dn) begin
                mv[raddr[9:2]] = 1'b1;
                mt[raddr[9:2]] = raddr[31:10];
                busy = 1'b0;
            end else if (busy) begin
                cnt--;
            end
        end
        if (!en_i) begin
            chk("freeze",
                {bus.mem_if_enable, bus.mem_if_pc, bus.inst_valid,
                 bus.inst, bus.inst_pc},
                {p_en, p_pc, p_v, p_inst, p_ipc});
        end else if (cl) begin
            busy      = 1'b0;
            req_since = 1'b0;
            exp_pc    = cpc & ~32'h3;
            chk("clr_out", {bus.inst_valid, bus.mem_if_enable}, 2'b00);
        end else begin
            if (bus.inst_valid && (!p_v || rd)) begin
                chk("inst_pc", bus.inst_pc, exp_pc);
                chk("inst_data", bus.inst, mem_word(exp_pc));
                if (!req_since) chk("hit_no_req", mhit(exp_pc), 1'b1);
                exp_pc    = exp_pc + 32'd4;
                req_since = 1'b0;
            end else if (p_v && !rd) begin
                chk("hold_inst", {bus.inst_valid, bus.inst, bus.inst_pc},
                    {1'b1, p_inst, p_ipc});
            end
            if (busy) begin
                chk("req_hold", {bus.mem_if_enable, bus.mem_if_pc},
                    {1'b1, raddr});
            end else if (bus.mem_if_enable) begin
                chk("req_pc", bus.mem_if_pc, exp_pc);
                chk("req_miss", mhit(exp_pc), 1'b0);
                busy      = 1'b1;
                raddr     = bus.mem_if_pc;
                cnt       = rand_lat ? int'($urandom_range(0, 3)) : lat - 1;
                req_since = 1'b1;
            end
        end
        snap();
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) mv[i] = 1'b0;
        busy      = 1'b0;
        req_since = 1'b0;
        exp_pc    = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_async", {bus.mem_if_enable, bus.inst_valid}, 2'b00);
        repeat (2) @(posedge clk);
        clear_model();
        @(negedge clk);
        rst = 1'b1;
        snap();
    endtask

    initial begin
        bus.inst_ready    = 1'b0;
        bus.mem_if_done   = 1'b0;
        bus.mem_if_result = 32'h0;
        clear_model();
        #1 rst = 1'b0;
        #1;
        chk("rst_en", bus.mem_if_enable, 1'b0);
        chk("rst_mem_pc", bus.mem_if_pc, 32'h0);
        chk("rst_valid", bus.inst_valid, 1'b0);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        snap();

        // cold start
        lat = 3;
        tick(1, 1, 0, 0);
        chk("cold_req", {bus.mem_if_enable, bus.mem_if_pc}, {1'b1, 32'h0});
        repeat (3) tick(1, 1, 0, 0);
        chk("cold_inst", {bus.inst_valid, bus.inst, bus.inst_pc},
            {1'b1, 32'h00000013, 32'h0});
        tick(1, 1, 0, 0);
        chk("cold_next", {bus.mem_if_enable, bus.mem_if_pc}, {1'b1, 32'h4});
        repeat (20) tick(1, 1, 0, 0);

        // cached loop re-fetch
        tick(1, 1, 1, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick(1, 1, 0, 0);
            chk("loop_pc", {bus.inst_valid, bus.inst_pc, bus.mem_if_enable},
                {1'b1, 32'(k * 4), 1'b0});
        end

        // backpressure on a hit
        tick(1, 1, 1, 32'h0);
        tick(0, 1, 0, 0);
        chk("bp_first", {bus.inst_valid, bus.inst_pc}, {1'b1, 32'h0});
        repeat (5) begin
            tick(0, 1, 0, 0);
            chk("bp_hold", {bus.inst_valid, bus.inst_pc, bus.mem_if_enable},
                {1'b1, 32'h0, 1'b0});
        end
        tick(1, 1, 0, 0);
        chk("bp_next", {bus.inst_valid, bus.inst_pc}, {1'b1, 32'h4});

        // flush during a miss
        lat = 10;
        tick(1, 1, 1, 32'h200);
        tick(1, 1, 0, 0);
        chk("fm_req", {bus.mem_if_enable, bus.mem_if_pc}, {1'b1, 32'h200});
        repeat (2) tick(1, 1, 0, 0);
        tick(1, 1, 1, 32'h103);
        chk("fm_drop", {bus.mem_if_enable, bus.inst_valid}, 2'b00);
        lat = 2;
        tick(1, 1, 0, 0);
        chk("fm_new", {bus.mem_if_enable, bus.mem_if_pc}, {1'b1, 32'h100});
        repeat (6) tick(1, 1, 0, 0);

        // conflict miss on index 0
        tick(1, 1, 1, 32'h400);
        tick(1, 1, 0, 0);
        chk("cf_req", {bus.mem_if_enable, bus.mem_if_pc}, {1'b1, 32'h400});
        repeat (4) tick(1, 1, 0, 0);
        tick(1, 1, 1, 32'h0);
        tick(1, 1, 0, 0);
        chk("cf_refetch", {bus.mem_if_enable, bus.mem_if_pc}, {1'b1, 32'h0});
        repeat (4) tick(1, 1, 0, 0);

        // pc wraps through zero
        tick(1, 1, 1, 32'hFFFFFFF8);
        repeat (16) tick(1, 1, 0, 0);

        // rdy freeze in MISS_WAIT, then reset mid-miss
        lat = 3;
        tick(1, 1, 1, 32'h300);
        tick(1, 1, 0, 0);
        chk("rf_req", {bus.mem_if_enable, bus.mem_if_pc}, {1'b1, 32'h300});
        repeat (4) tick(1, 0, 0, 0);
        tick(1, 1, 0, 0);
        do_reset();
        tick(1, 1, 0, 0);
        chk("rst_refetch", {bus.mem_if_enable, bus.mem_if_pc}, {1'b1, 32'h0});

        // randomized traffic
        rand_lat = 1'b1;
        repeat (3000) begin
            logic [31:0] cpc;
            cpc = (32'($urandom_range(0, 3)) << 10)
                | (32'($urandom_range(0, 31)) << 2)
                | 32'($urandom_range(0, 3));
            tick(($urandom % 4) != 0, ($urandom % 10) != 0,
                 ($urandom % 40) == 0, cpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ifetch_icache.md
Name: ifetch_icache

Overview:
- Instruction-fetch front end with a direct-mapped instruction cache.
- Sits between the decoder/issue stage and the memory controller's instruction-fetch port.
- Holds the fetch PC and looks it up in the cache. On a miss, requests the word from the memory controller and fills the cache.
- Presents one instruction at a time to the decoder through a valid/ready holding register; clr redirects the PC.

Parameters:
- INDEX_W, 8, cache index width; number of lines = 2^INDEX_W, one 32-bit word per line.
- RESET_PC, 32'h0, fetch PC after reset.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global enable; when 0, all state is frozen.
- clr  input  1  pipeline flush / redirect, synchronous.
- clr_pc  input  32  redirect target, sampled when clr=1.
- mem_if_enable  output  1  fetch request to the memory controller.
- mem_if_pc  output  32  fetch address; word aligned.
- mem_if_done  input  1  one-cycle pulse: mem_if_result is valid.
- mem_if_result  input  32  fetched instruction word.
- inst_valid  output  1  instruction holding register is full.
- inst  output  32  instruction word.
- inst_pc  output  32  PC of inst.
- inst_ready  input  1  decoder accepts inst this cycle.

Behaviour:
- Address split:
  - index = pc[INDEX_W+1:2]
  - tag = pc[31:INDEX_W+2]
  - pc[1:0] is always 0; clr_pc[1:0] is forced to 0 on capture.
- Reset (rst=0, asynchronous):
  - pc = RESET_PC.
  - All line valid bits = 0.
  - state = LOOKUP.
  - mem_if_enable = 0, mem_if_pc = 0, inst_valid = 0, inst = 0, inst_pc = 0.
  - Tag/data arrays need no reset.
- rdy=0: no register changes; outputs hold their values.
- Slot free: the holding register is free when inst_valid=0, or when inst_valid=1 and inst_ready=1 in the same cycle (accept and refill in the same cycle are allowed).
- State LOOKUP, slot free:
  - Hit (valid[index] && tag match): next cycle inst=data, inst_pc=pc, inst_valid=1, pc=pc+4. Single-cycle hit latency, sustaining 1 instruction/cycle.
  - Miss: next cycle mem_if_enable=1, mem_if_pc=pc, state=MISS_WAIT.
- State LOOKUP, slot not free: no change.
- State MISS_WAIT:
  - mem_if_enable and mem_if_pc are held stable until mem_if_done.
  - On mem_if_done: write data/tag and set valid for the line, inst=mem_if_result, inst_pc=pc, inst_valid=1, pc=pc+4, mem_if_enable=0, state=LOOKUP.
  - The holding register is guaranteed free here because a miss is only started when the slot is free.
- inst_valid clears on accept (inst_valid && inst_ready) unless refilled in the same cycle.
- clr=1 (highest priority, rdy=1):
  - Next cycle: pc=clr_pc&~3, inst_valid=0, mem_if_enable=0, state=LOOKUP.
  - The memory controller drops its own in-flight request on clr.
  - If mem_if_done coincides with clr: the line is still written to the cache (data is correct), but the word is not presented.
  - Cache valid bits are not cleared by clr.
- PC arithmetic is 32-bit modulo: 32'hFFFFFFFC + 4 = 32'h0.
- No speculation beyond sequential pc+4; branch redirection arrives only via clr.
- Outputs are registered; no combinational path from mem_if_done or inst_ready to any output.

Test Plan:
- Cold start, RESET_PC=0, memory word[0]=32'h00000013, mem_if_done 3 cycles after request, inst_ready=1 → mem_if_enable=1 with mem_if_pc=0 one cycle after reset release; inst_valid=1, inst=32'h00000013, inst_pc=0 the cycle after done; next request mem_if_pc=4.
- Re-fetch of cached loop: clr with clr_pc=0 after PCs 0..0xC are filled → inst_pc sequence 0,4,8,0xC on four consecutive cycles; mem_if_enable stays 0 until pc=0x10.
- Backpressure: hit with inst_ready=0 for 5 cycles → inst/inst_pc stable, pc not advanced, no memory request; inst_ready=1 → next instruction on the following cycle.
- Flush during miss: clr with clr_pc=32'h103 two cycles into MISS_WAIT → mem_if_enable=0 next cycle, inst_valid=0, then a new request at mem_if_pc=32'h100.
- Conflict miss: fill pc=0x000, then fetch pc=0x400 (same index, INDEX_W=8) → miss and refill; fetching 0x000 again misses.
- rdy=0 during MISS_WAIT with mem_if_done held low → all outputs frozen; rst low mid-miss → mem_if_enable=0, inst_valid=0 immediately, next fetch from RESET_PC.
